// File: rtl/elbeth_fetch_unit.sv
// Elbeth instruction fetch stage: PC register, single-outstanding imem request,
// redirect drop handling and a one-entry skid buffer towards decode.
module elbeth_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_plus4,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic xfer;
    logic out_free;
    logic load_new;

    assign imem_req  = (state != IDLE);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    assign xfer     = imem_req & imem_ready;
    assign out_free = !if_valid | !stall;
    assign load_new = (state == WAIT) & xfer & !redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_pc   <= 32'd0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= NOP;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_instr   <= NOP;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= pc_next;
                    end else if (!skid_valid) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (xfer) begin
                        pc <= pc_next;
                        if (redirect || !out_free) begin
                            state <= IDLE;
                        end
                    end else if (redirect) begin
                        redir_pc <= pc_next;
                        state    <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        redir_pc <= pc_next;
                    end
                    // Data for the superseded address is thrown away here.
                    if (xfer) begin
                        pc    <= redirect ? pc_next : redir_pc;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A redirect flushes everything held for decode.
            if (redirect) begin
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_free) begin
                if (load_new) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= pc;
                    skid_instr <= imem_rdata;
                end
            end else if (skid_valid) begin
                if_valid   <= 1'b1;
                if_pc      <= skid_pc;
                if_instr   <= skid_instr;
                skid_valid <= 1'b0;
            end else if (load_new) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
